mips_multicycle_core: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle MIPS top.
- Fetch, decode, execute, memory and write-back share one ALU and one unified memory port, sequenced by an FSM.
- The memory port uses a req/ready handshake, so wait-stated memories are supported.
- Register file, ALU, sign-extend and branch/jump target logic are internal; the block is a self-contained core.

---
 rtl/mips_multicycle_core.sv | 176 +++++++++++++++++
 tb/tb_mips_multicycle_core.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS subset core: one ALU and one unified req/ready memory port, sequenced by an FSM.
// Three to five cycles per instruction with zero-wait memory; each cycle mem_ready is low adds one stall cycle.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter bit          HALT_ON_ILLEGAL = 1'b1,
    parameter bit          CHECK_ALIGN     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic        retire,
    output logic        halted,
    output logic [1:0]  err_code
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_J = 6'h02, OP_JAL = 6'h03;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A, F_SLL = 6'h00, F_JR = 6'h08;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    state_t      state;
    logic [31:0] ir, a, b, alu_out, mdr, br_target;
    logic [31:0] regs [32];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [25:0] imm26;
    logic [31:0] imm_sext, alu_res;
    logic        is_r_alu, is_jr, is_mem, is_ctrl, legal, misaligned;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    assign op       = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign shamt    = ir[10:6];
    assign funct    = ir[5:0];
    assign imm26    = ir[25:0];
    assign imm_sext = {{16{ir[15]}}, ir[15:0]};

    always_comb begin
        is_r_alu = (op == OP_RTYPE) && (funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL});
        is_jr    = (op == OP_RTYPE) && (funct == F_JR);
        is_mem   = (op == OP_LW) || (op == OP_SW);
        is_ctrl  = is_jr || (op == OP_BEQ) || (op == OP_J) || (op == OP_JAL);
        legal    = is_r_alu || is_ctrl || is_mem || (op == OP_ADDI);
    end

    // Shared ALU: R-type by funct, everything else (addi, lw/sw address) is A + sext(imm)
    always_comb begin
        alu_res = a + imm_sext;
        if (op == OP_RTYPE) begin
            case (funct)
                F_SUB:   alu_res = a - b;
                F_AND:   alu_res = a & b;
                F_OR:    alu_res = a | b;
                F_SLT:   alu_res = {31'd0, $signed(a) < $signed(b)};
                F_SLL:   alu_res = b << shamt;
                default: alu_res = a + b;
            endcase
        end
        misaligned = alu_res[1:0] != 2'b00;
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = alu_out;
        if (state == EXEC && op == OP_JAL) begin
            rf_we    = 1'b1;
            rf_waddr = 5'd31;
            rf_wdata = pc;
        end else if (state == WB) begin
            rf_we    = 1'b1;
            rf_waddr = (op == OP_RTYPE) ? rd : rt;
            rf_wdata = (op == OP_LW) ? mdr : alu_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (rf_we && rf_waddr != 5'd0) begin
            regs[rf_waddr] <= rf_wdata;
        end
    end

    // Port and retire decode are combinational on state so a zero-wait access completes in its own cycle
    always_comb begin
        mem_req   = !rst && (state == FETCH || state == MEM);
        mem_we    = !rst && state == MEM && op == OP_SW;
        mem_addr  = '0;
        mem_wdata = mem_we ? b : '0;
        if (!rst && state == FETCH) mem_addr = pc;
        else if (!rst && state == MEM) mem_addr = alu_out;
        retire = !rst && ((state == DECODE && !legal && !HALT_ON_ILLEGAL) ||
                          (state == EXEC && is_ctrl) ||
                          (state == MEM && op == OP_SW && mem_ready) ||
                          (state == WB));
        halted = state == HALT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            alu_out   <= '0;
            mdr       <= '0;
            br_target <= '0;
            err_code  <= 2'b00;
        end else begin
            case (state)
                FETCH: if (mem_ready) begin
                    ir    <= mem_rdata;
                    pc    <= pc + 32'd4;
                    state <= DECODE;
                end
                DECODE: begin
                    a         <= regs[rs];
                    b         <= regs[rt];
                    br_target <= pc + {imm_sext[29:0], 2'b00};
                    if (legal) state <= EXEC;
                    else if (HALT_ON_ILLEGAL) begin
                        err_code <= 2'b01;
                        state    <= HALT;
                    end else state <= FETCH;
                end
                EXEC: begin
                    if (is_jr) begin
                        pc    <= a;
                        state <= FETCH;
                    end else if (op == OP_BEQ) begin
                        if (a == b) pc <= br_target;
                        state <= FETCH;
                    end else if (op == OP_J || op == OP_JAL) begin
                        pc    <= {pc[31:28], imm26, 2'b00};
                        state <= FETCH;
                    end else if (is_mem) begin
                        if (CHECK_ALIGN && misaligned) begin
                            err_code <= 2'b10;
                            state    <= HALT;
                        end else begin
                            alu_out <= {alu_res[31:2], 2'b00};
                            state   <= MEM;
                        end
                    end else begin
                        alu_out <= alu_res;
                        state   <= WB;
                    end
                end
                MEM: if (mem_ready) begin
                    if (op == OP_SW) state <= FETCH;
                    else begin
                        mdr   <= mem_rdata;
                        state <= WB;
                    end
                end
                WB:      state <= FETCH;
                HALT:    state <= HALT;
                default: state <= HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Self-checking bench: behavioural wait-stated memory plus a store scoreboard comparing each retired write.
module tb_mips_multicycle_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, retire, halted;
    logic [31:0] mem_addr, mem_wdata, pc;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [1:0]  err_code;

    mips_multicycle_core dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
        .retire(retire), .halted(halted), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [0:1023];
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];
    int          wait_cycles = 0;
    bit          stall_hi = 1'b0;
    int          wcnt = 0;
    bit          wr_active = 1'b0;
    logic [31:0] wr_addr = '0, wr_data = '0;
    int          unstable = 0;
    int          wreq_cycles = 0;

    // Memory responder: ready after wait_cycles stall cycles; addresses >= 0x100 can be stalled forever
    always @(negedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                if (wr_active && (mem_addr !== wr_addr || mem_wdata !== wr_data)) unstable++;
                wr_addr = mem_addr;
                wr_data = mem_wdata;
                wreq_cycles++;
            end
            if (stall_hi && mem_addr >= 32'h100) begin
                mem_ready = 1'b0;
            end else if (wcnt >= wait_cycles) begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr[11:2]];
                if (mem_we) begin
                    mem[mem_addr[11:2]] = mem_wdata;
                    obs_q.push_back({mem_addr, mem_wdata});
                end
                wcnt = 0;
            end else begin
                mem_ready = 1'b0;
                wcnt++;
            end
            wr_active = mem_we && !mem_ready;
        end else begin
            mem_ready = 1'b0;
            wcnt      = 0;
            wr_active = 1'b0;
        end
    end

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] addr);
        return {op, addr[27:2]};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    endtask

    task automatic hold_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        obs_q.delete();
        unstable    = 0;
        wreq_cycles = 0;
    endtask

    task automatic run(input int n, input int budget, output int cyc);
        int got = 0;
        cyc = 0;
        while (got < n && cyc < budget) begin
            @(negedge clk); #1;
            cyc++;
            if (retire === 1'b1) got++;
        end
        vectors++;
        if (got < n) begin
            miscompares++;
            $display("FAIL run_timeout retired=%0d required=%0d", got, n);
        end
    endtask

    task automatic check_pc(input string name, input logic [31:0] exp_pc);
        @(posedge clk); #1;
        vectors++;
        if (pc !== exp_pc) begin
            miscompares++;
            $display("FAIL %s pc=%h required=%h", name, pc, exp_pc);
        end
    endtask

    task automatic wait_halt(input int budget);
        int n = 0;
        while (halted !== 1'b1 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        vectors++;
        if (halted !== 1'b1) begin
            miscompares++;
            $display("FAIL halt_timeout halted=%b required=1", halted);
        end
    endtask

    task automatic check_writes(input string name);
        logic [63:0] e, o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("FAIL %s missing write required addr=%h data=%h", name, e[63:32], e[31:0]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL %s write addr=%h data=%h required addr=%h data=%h",
                             name, o[63:32], o[31:0], e[63:32], e[31:0]);
                end
            end
        end
        vectors++;
        if (obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s extra_writes=%0d required=0", name, obs_q.size());
        end
    endtask

    task automatic test_reset();
        hold_reset();
        vectors++;
        if ({mem_req, mem_we, retire, halted, err_code} !== 6'b0 || mem_addr !== 32'h0 ||
            mem_wdata !== 32'h0 || pc !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state req=%b we=%b ret=%b halt=%b err=%b addr=%h wd=%h pc=%h required all zero",
                     mem_req, mem_we, retire, halted, err_code, mem_addr, mem_wdata, pc);
        end
        clear_mem();
        rst = 1'b0;
        @(negedge clk); #1;
        vectors++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL first_fetch req=%b we=%b addr=%h required 1 0 00000000", mem_req, mem_we, mem_addr);
        end
        @(posedge clk); #1;
        vectors++;
        if (pc !== 32'h4 || mem_req !== 1'b0 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL after_fetch pc=%h req=%b halt=%b required 00000004 0 0", pc, mem_req, halted);
        end
    endtask

    task automatic test_alu();
        int c;
        hold_reset();
        clear_mem();
        mem[0]  = enc_i(6'h08, 0, 1, 16'd5);
        mem[1]  = enc_i(6'h08, 0, 2, 16'hFFFD);
        mem[2]  = enc_r(1, 2, 3, 0, 6'h20);
        mem[3]  = enc_r(2, 1, 4, 0, 6'h2A);
        mem[4]  = enc_r(0, 1, 5, 4, 6'h00);
        mem[5]  = enc_r(1, 2, 7, 0, 6'h22);
        mem[6]  = enc_r(1, 2, 8, 0, 6'h24);
        mem[7]  = enc_r(1, 2, 9, 0, 6'h25);
        mem[8]  = enc_r(1, 2, 10, 0, 6'h2A);
        mem[9]  = enc_i(6'h08, 0, 0, 16'd7);
        mem[10] = enc_i(6'h2B, 0, 3, 16'h100);  exp_q.push_back({32'h100, 32'd2});
        mem[11] = enc_i(6'h2B, 0, 4, 16'h104);  exp_q.push_back({32'h104, 32'd1});
        mem[12] = enc_i(6'h2B, 0, 5, 16'h108);  exp_q.push_back({32'h108, 32'h50});
        mem[13] = enc_i(6'h2B, 0, 7, 16'h10C);  exp_q.push_back({32'h10C, 32'd8});
        mem[14] = enc_i(6'h2B, 0, 8, 16'h110);  exp_q.push_back({32'h110, 32'd5});
        mem[15] = enc_i(6'h2B, 0, 9, 16'h114);  exp_q.push_back({32'h114, 32'hFFFF_FFFD});
        mem[16] = enc_i(6'h2B, 0, 10, 16'h118); exp_q.push_back({32'h118, 32'd0});
        mem[17] = enc_i(6'h2B, 0, 0, 16'h11C);  exp_q.push_back({32'h11C, 32'd0});
        rst = 1'b0;
        run(5, 100, c);
        vectors++;
        if (c !== 20) begin
            miscompares++;
            $display("FAIL alu_5_retire_cycles cycles=%0d required=20", c);
        end
        run(13, 200, c);
        vectors++;
        if (c !== 52) begin
            miscompares++;
            $display("FAIL alu_store_cycles cycles=%0d required=52", c);
        end
        check_writes("alu");
    endtask

    task automatic test_mem_wait();
        int c;
        int exp_cyc[5] = '{7, 6, 10, 11, 10};
        hold_reset();
        clear_mem();
        wait_cycles = 3;
        mem[0]  = enc_i(6'h08, 0, 1, 16'd5);
        mem[1]  = enc_j(6'h02, 32'h20);
        mem[8]  = enc_i(6'h2B, 0, 1, 16'h8);   exp_q.push_back({32'h8, 32'd5});
        mem[9]  = enc_i(6'h23, 0, 6, 16'h8);
        mem[10] = enc_i(6'h2B, 0, 6, 16'h100); exp_q.push_back({32'h100, 32'd5});
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            run(1, 50, c);
            vectors++;
            if (c !== exp_cyc[k]) begin
                miscompares++;
                $display("FAIL memwait_instr%0d cycles=%0d required=%0d", k, c, exp_cyc[k]);
            end
        end
        vectors++;
        if (unstable !== 0 || wreq_cycles !== 8) begin
            miscompares++;
            $display("FAIL memwait_hold unstable=%0d wreq_cycles=%0d required 0 8", unstable, wreq_cycles);
        end
        check_writes("memwait");
        wait_cycles = 0;
    endtask

    task automatic test_control();
        int c;
        hold_reset();
        clear_mem();
        mem[0]  = enc_i(6'h08, 0, 1, 16'd3);
        mem[1]  = enc_i(6'h08, 0, 2, 16'd3);
        mem[2]  = enc_i(6'h04, 1, 0, 16'd5);
        mem[4]  = enc_i(6'h04, 1, 2, 16'd2);
        mem[5]  = enc_i(6'h08, 0, 20, 16'd1);
        mem[6]  = enc_i(6'h08, 0, 20, 16'd1);
        mem[7]  = enc_j(6'h03, 32'h40);
        mem[8]  = enc_i(6'h2B, 0, 20, 16'h104);
        mem[16] = enc_i(6'h2B, 0, 31, 16'h100);
        mem[17] = enc_r(31, 0, 0, 0, 6'h08);
        exp_q.push_back({32'h100, 32'h20});
        exp_q.push_back({32'h104, 32'h0});
        rst = 1'b0;
        run(4, 100, c);
        vectors++;
        if (c !== 15) begin
            miscompares++;
            $display("FAIL beq_not_taken_cycles cycles=%0d required=15", c);
        end
        run(1, 20, c);
        vectors++;
        if (c !== 3) begin
            miscompares++;
            $display("FAIL beq_cycles cycles=%0d required=3", c);
        end
        check_pc("beq_taken", 32'h1C);
        run(1, 20, c);
        vectors++;
        if (c !== 3) begin
            miscompares++;
            $display("FAIL jal_cycles cycles=%0d required=3", c);
        end
        check_pc("jal", 32'h40);
        run(1, 20, c);
        run(1, 20, c);
        vectors++;
        if (c !== 3) begin
            miscompares++;
            $display("FAIL jr_cycles cycles=%0d required=3", c);
        end
        check_pc("jr", 32'h20);
        run(1, 20, c);
        check_writes("control");
    endtask

    task automatic test_faults();
        int c;
        int bad = 0;
        hold_reset();
        clear_mem();
        mem[0] = enc_i(6'h08, 0, 1, 16'd3);
        mem[1] = 32'hFC00_0000;
        rst = 1'b0;
        run(1, 20, c);
        wait_halt(20);
        vectors++;
        if (err_code !== 2'b01 || pc !== 32'h8) begin
            miscompares++;
            $display("FAIL illegal err=%b pc=%h required 01 00000008", err_code, pc);
        end
        repeat (10) begin
            @(negedge clk); #1;
            if (mem_req !== 1'b0 || retire !== 1'b0 || halted !== 1'b1) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL halt_quiet bad_cycles=%0d required=0", bad);
        end
        hold_reset();
        vectors++;
        if (halted !== 1'b0 || err_code !== 2'b00) begin
            miscompares++;
            $display("FAIL halt_cleared halt=%b err=%b required 0 00", halted, err_code);
        end
        clear_mem();
        mem[0] = enc_i(6'h08, 0, 1, 16'd6);
        mem[1] = enc_i(6'h23, 1, 2, 16'd0);
        rst = 1'b0;
        run(1, 20, c);
        wait_halt(20);
        vectors++;
        if (err_code !== 2'b10 || pc !== 32'h8) begin
            miscompares++;
            $display("FAIL misaligned err=%b pc=%h required 10 00000008", err_code, pc);
        end
        check_writes("faults");
    endtask

    task automatic test_reset_mid();
        int c;
        int rets = 0;
        hold_reset();
        clear_mem();
        mem[0]  = enc_i(6'h23, 0, 6, 16'h100);
        mem[64] = 32'h1234_5678;
        stall_hi = 1'b1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk); #1;
            if (retire === 1'b1) rets++;
        end
        vectors++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin
            miscompares++;
            $display("FAIL mid_mem_req req=%b we=%b addr=%h required 1 0 00000100", mem_req, mem_we, mem_addr);
        end
        repeat (3) begin
            @(negedge clk); #1;
            if (retire === 1'b1) rets++;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (mem_req !== 1'b0 || pc !== 32'h0 || retire !== 1'b0 || rets !== 0) begin
            miscompares++;
            $display("FAIL mid_reset req=%b pc=%h ret=%b stall_retires=%0d required 0 00000000 0 0",
                     mem_req, pc, retire, rets);
        end
        stall_hi = 1'b0;
        mem[0] = enc_i(6'h2B, 0, 6, 16'h104);
        exp_q.push_back({32'h104, 32'h0});
        obs_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        run(1, 20, c);
        check_writes("reset_mid");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_mem_wait();
        test_control();
        test_faults();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
